// File: rtl/intr_pkg.sv
// intr_pkg: shared types and constants for the interrupt controller.
//   intr_state_t       - request FSM states (IDLE, REQ, ACKED)
//   INTR_N_SRC_DEFAULT - default number of interrupt sources
//   cause_width()      - width of the cause index for a given source count
package intr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACKED
    } intr_state_t;

    localparam int INTR_N_SRC_DEFAULT = 4;

    // A single-source configuration still needs a 1-bit cause field.
    function automatic int cause_width(input int n_src);
        return (n_src <= 1) ? 1 : $clog2(n_src);
    endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// intr_prio_enc: combinational fixed-priority encoder, lowest index wins.
//   pending_i [N]  - request vector
//   any_o          - at least one bit of pending_i is set
//   idx_o [W]      - index of the lowest set bit (0 when none set)
module intr_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] pending_i,
    output logic         any_o,
    output logic [W-1:0] idx_o
);

    localparam int unsigned NU = N;

    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (pending_i[i] && !any_o) begin
                any_o = 1'b1;
                idx_o = W'(i);
            end
        end
    end

endmodule

// File: rtl/intr_controller.sv
// intr_controller: latches peripheral event pulses into pending bits,
// arbitrates them by fixed priority (lowest index first) and presents a
// single request plus cause index to the CPU, retired on a rising ack.
//   clk         - system clock
//   reset       - synchronous active-high reset
//   src_pulse   - per-source event pulses (one event per high cycle)
//   intr_en     - global interrupt enable from the CPU status register
//   ack         - CPU acknowledge level; only 0->1 transitions retire
//   clr_overrun - single-cycle clear of all overrun bits
//   intr        - registered interrupt request
//   cause       - registered index of the requested source
//   pending     - latched, unserviced events
//   overrun     - sticky flag: event arrived while already pending
module intr_controller
    import intr_pkg::*;
#(
    parameter int N_SRC = INTR_N_SRC_DEFAULT,
    parameter int CW    = cause_width(N_SRC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_pulse,
    input  logic             intr_en,
    input  logic             ack,
    input  logic             clr_overrun,
    output logic             intr,
    output logic [CW-1:0]    cause,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] overrun
);

    intr_state_t      state_q;
    logic             intr_q;
    logic [CW-1:0]    cause_q;
    logic             ack_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] overrun_q, overrun_d;

    logic             prio_any;
    logic [CW-1:0]    prio_idx;
    logic             ack_rise;
    logic             retire;
    logic [N_SRC-1:0] clr_vec;
    logic [N_SRC-1:0] ovr_set;

    intr_prio_enc #(
        .N (N_SRC),
        .W (CW)
    ) u_prio (
        .pending_i (pending_q),
        .any_o     (prio_any),
        .idx_o     (prio_idx)
    );

    assign ack_rise = ack && !ack_q;
    assign retire   = (state_q == REQ) && ack_rise;

    always_comb begin
        clr_vec = '0;
        if (retire) begin
            clr_vec = N_SRC'(1) << cause_q;
        end
        // A new event on the source being retired survives the clear, and
        // because its old pending state was consumed it is not an overrun.
        ovr_set   = src_pulse & pending_q & ~clr_vec;
        pending_d = (pending_q & ~clr_vec) | src_pulse;
        overrun_d = (clr_overrun ? '0 : overrun_q) | ovr_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q     <= 1'b0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            ack_q     <= ack;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    // Request FSM with registered intr/cause; cause is frozen outside IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            intr_q  <= 1'b0;
            cause_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (intr_en && prio_any) begin
                        cause_q <= prio_idx;
                        intr_q  <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (ack_rise) begin
                        intr_q  <= 1'b0;
                        state_q <= ACKED;
                    end else if (!intr_en) begin
                        intr_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                ACKED: begin
                    if (!ack) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    intr_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign intr    = intr_q;
    assign cause   = cause_q;
    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_intr_controller.sv
module tb_intr_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] src_pulse;
    logic       intr_en;
    logic       ack;
    logic       clr_overrun;
    logic       intr;
    logic [1:0] cause;
    logic [3:0] pending;
    logic [3:0] overrun;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      tag;
        logic       intr;
        logic       chk_cause;
        logic [1:0] cause;
        logic [3:0] pend;
        logic [3:0] ovr;
    } exp_t;

    exp_t sb[$];

    intr_controller #(.N_SRC(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .src_pulse   (src_pulse),
        .intr_en     (intr_en),
        .ack         (ack),
        .clr_overrun (clr_overrun),
        .intr        (intr),
        .cause       (cause),
        .pending     (pending),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Queue the expected outputs for the coming edge, advance one edge,
    // then drain the scoreboard against the DUT outputs.
    task automatic step(input string tag, input logic e_intr, input logic chk_c,
                        input logic [1:0] e_cause, input logic [3:0] e_pend,
                        input logic [3:0] e_ovr);
        exp_t e;
        e.tag = tag; e.intr = e_intr; e.chk_cause = chk_c;
        e.cause = e_cause; e.pend = e_pend; e.ovr = e_ovr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            assert (intr === e.intr) else begin
                n_bad++;
                $error("FAIL %s intr: observed %0b expected %0b", e.tag, intr, e.intr);
            end
            n_cmp++;
            assert (pending === e.pend) else begin
                n_bad++;
                $error("FAIL %s pending: observed %b expected %b", e.tag, pending, e.pend);
            end
            n_cmp++;
            assert (overrun === e.ovr) else begin
                n_bad++;
                $error("FAIL %s overrun: observed %b expected %b", e.tag, overrun, e.ovr);
            end
            if (e.chk_cause) begin
                n_cmp++;
                assert (cause === e.cause) else begin
                    n_bad++;
                    $error("FAIL %s cause: observed %0d expected %0d", e.tag, cause, e.cause);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; src_pulse = '0; intr_en = 1'b0; ack = 1'b0; clr_overrun = 1'b0;
        @(posedge clk); #1;
        step("reset", 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000);

        // Single source, 2-edge latency, long ack level
        reset = 1'b0; intr_en = 1'b1; src_pulse = 4'b0100;
        step("t1_latch", 1'b0, 1'b0, 2'd0, 4'b0100, 4'b0000);
        src_pulse = '0;
        step("t1_req", 1'b1, 1'b1, 2'd2, 4'b0100, 4'b0000);
        ack = 1'b1;
        step("t1_retire", 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
        for (int i = 0; i < 7; i++)
            step("t1_ackhold", 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
        ack = 1'b0;
        step("t1_idle", 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
        step("t1_norereq", 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);

        // Two sources at once: priority, then back-to-back service
        src_pulse = 4'b1010;
        step("t2_latch", 1'b0, 1'b0, 2'd0, 4'b1010, 4'b0000);
        src_pulse = '0;
        step("t2_req1", 1'b1, 1'b1, 2'd1, 4'b1010, 4'b0000);
        ack = 1'b1;
        step("t2_ret1", 1'b0, 1'b0, 2'd0, 4'b1000, 4'b0000);
        ack = 1'b0;
        step("t2_acklow", 1'b0, 1'b0, 2'd0, 4'b1000, 4'b0000);
        step("t2_req3", 1'b1, 1'b1, 2'd3, 4'b1000, 4'b0000);
        ack = 1'b1;
        step("t2_ret3", 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
        ack = 1'b0;
        step("t2_idle", 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);

        // Global enable gating and withdrawal
        intr_en = 1'b0; src_pulse = 4'b0001;
        step("t3_latch_dis", 1'b0, 1'b0, 2'd0, 4'b0001, 4'b0000);
        src_pulse = '0;
        step("t3_hold_dis", 1'b0, 1'b0, 2'd0, 4'b0001, 4'b0000);
        intr_en = 1'b1;
        step("t3_enable", 1'b1, 1'b1, 2'd0, 4'b0001, 4'b0000);
        intr_en = 1'b0;
        step("t3_withdraw", 1'b0, 1'b0, 2'd0, 4'b0001, 4'b0000);

        // Overrun set, clear, and clear-vs-set collision
        src_pulse = 4'b1000;
        step("t4_pend3", 1'b0, 1'b0, 2'd0, 4'b1001, 4'b0000);
        step("t4_ovr3", 1'b0, 1'b0, 2'd0, 4'b1001, 4'b1000);
        src_pulse = '0;
        step("t4_sticky", 1'b0, 1'b0, 2'd0, 4'b1001, 4'b1000);
        clr_overrun = 1'b1;
        step("t4_clr", 1'b0, 1'b0, 2'd0, 4'b1001, 4'b0000);
        src_pulse = 4'b1000;
        step("t4_clr_vs_set", 1'b0, 1'b0, 2'd0, 4'b1001, 4'b1000);
        src_pulse = '0;
        step("t4_clr2", 1'b0, 1'b0, 2'd0, 4'b1001, 4'b0000);
        clr_overrun = 1'b0;

        // Ack already high on entry to REQ does not retire
        ack = 1'b1;
        step("t5_ackpre", 1'b0, 1'b0, 2'd0, 4'b1001, 4'b0000);
        intr_en = 1'b1;
        step("t5_req0", 1'b1, 1'b1, 2'd0, 4'b1001, 4'b0000);
        step("t5_stale1", 1'b1, 1'b1, 2'd0, 4'b1001, 4'b0000);
        step("t5_stale2", 1'b1, 1'b1, 2'd0, 4'b1001, 4'b0000);
        ack = 1'b0;
        step("t5_acklow", 1'b1, 1'b1, 2'd0, 4'b1001, 4'b0000);
        ack = 1'b1;
        step("t5_retire", 1'b0, 1'b0, 2'd0, 4'b1000, 4'b0000);
        ack = 1'b0;
        step("t5_idle", 1'b0, 1'b0, 2'd0, 4'b1000, 4'b0000);
        step("t5_req3", 1'b1, 1'b1, 2'd3, 4'b1000, 4'b0000);

        // Retire and new event on the same source in one edge
        ack = 1'b1; src_pulse = 4'b1000;
        step("t6_setwins", 1'b0, 1'b0, 2'd0, 4'b1000, 4'b0000);
        ack = 1'b0; src_pulse = '0;
        step("t6_idle", 1'b0, 1'b0, 2'd0, 4'b1000, 4'b0000);
        step("t6_rereq", 1'b1, 1'b1, 2'd3, 4'b1000, 4'b0000);
        src_pulse = 4'b0001;
        step("t6_frozen", 1'b1, 1'b1, 2'd3, 4'b1001, 4'b0000);
        src_pulse = '0; reset = 1'b1;
        step("t6_reset", 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000);
        reset = 1'b0;
        step("t6_after", 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
